ntps_ethlite_rx_drain: RTL and testbench
========================================

# ntps_ethlite_rx_drain

AXI4-Lite master that empties the Ethernet Lite MAC's receive ping buffer into a 32-bit word stream for the NTP packet path. It sits directly upstream of the MAC's AXI4-Lite slave port. It polls the RX control register, reads a fixed-length frame prefix word by word, and presents each word on a valid/ready stream. It then writes the control register to release the buffer back to the MAC.

## Interface
Parameters:
- FRAME_WORDS, 24, words read per frame (24 words = 96 bytes, covers Eth+IPv4+UDP+NTP); legal 1..508
- POLL_GAP, 16, idle cycles between consecutive status polls; legal 1..65535
- RX_BASE, 13'h1000, byte address of the first RX ping data word
- RX_CTRL, 13'h17FC, byte address of the RX ping control register

Ports:
- s_axi_aclk  in  1  clock; the only clock
- s_axi_aresetn  in  1  reset, asynchronous, active-low
- enable  in  1  1 = polling allowed; 0 = stop after the current frame completes
- m_axi_araddr  out  13  read address
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  32  read data
- m_axi_rresp  in  2  read response
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready
- m_axi_awaddr  out  13  write address
- m_axi_awvalid  out  1  write address valid
- m_axi_awready  in  1  write address ready
- m_axi_wdata  out  32  write data
- m_axi_wstrb  out  4  write strobes; always 4'hF
- m_axi_wvalid  out  1  write data valid
- m_axi_wready  in  1  write data ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  write response valid
- m_axi_bready  out  1  write response ready
- frm_data  out  32  frame word, little-endian byte order as stored by the MAC
- frm_valid  out  1  frm_data valid
- frm_last  out  1  marks word FRAME_WORDS-1
- frm_ready  in  1  downstream accepts the word
- err_sticky  out  1  set on any non-OKAY rresp or bresp; cleared only by reset
- frame_cnt  out  16  frames released; wraps 16'hFFFF -> 0

## Operation
- States and transitions:
  - WAIT: gap counter runs to POLL_GAP-1, then goes to POLL_AR if enable=1. Otherwise it stays in WAIT with the counter held at POLL_GAP-1.
  - POLL_AR: araddr=RX_CTRL, arvalid=1 until arready. Then goes to POLL_R.
  - POLL_R: rready=1. On rvalid, if rdata[0]=1 and rresp=OKAY, go to DATA_AR with word index 0. Otherwise go to WAIT and clear the gap counter.
  - DATA_AR: araddr=RX_BASE + 4*index, arvalid=1 until arready. Then goes to DATA_R.
  - DATA_R: rready=1. On rvalid, capture rdata into frm_data and go to DATA_OUT.
  - DATA_OUT: frm_valid=1; frm_last=1 when index=FRAME_WORDS-1. On frm_ready, if last go to CLR, else increment index and go to DATA_AR.
  - CLR: awaddr=RX_CTRL, wdata=32'h0, awvalid=wvalid=1. Each valid drops independently on its own ready. When both channels are done, go to CLR_B.
  - CLR_B: bready=1. On bvalid, increment frame_cnt, clear the gap counter, and go to WAIT.
- Only one AXI transaction is outstanding at a time. Read and write channels are never active together.
- Non-OKAY rresp in DATA_R: the word is still forwarded and err_sticky is set. Non-OKAY bresp: err_sticky is set; the block still proceeds to WAIT.
- Non-OKAY rresp in POLL_R sets err_sticky and is treated as "no frame".
- enable deasserted mid-frame has no effect until the frame reaches WAIT. The buffer is always released.
- Address arithmetic is 13-bit, unsigned, with no wrap checking. This is legal by the FRAME_WORDS range.

## Timing
- Reset (async assert, synchronous deassert in the clock domain):
  - State is WAIT with the gap counter at 0.
  - All valid/ready outputs are 0.
  - araddr, awaddr, wdata, frm_data, frm_last, err_sticky and frame_cnt are 0; wstrb is 4'hF.
- Reset mid-transaction drops all handshakes immediately. The MAC buffer stays unreleased and is re-polled after reset.
- AXI valids are registered. Once asserted, arvalid, awvalid and wvalid stay high with stable address/data until their handshake completes.
- Minimum per data word is 3 cycles: AR handshake, R capture, out handshake (arready, rvalid and frm_ready all immediate).
- Minimum poll cost is POLL_GAP+2 cycles. The first poll after reset issues arvalid at cycle POLL_GAP+1.
- frm_data and frm_last stay stable while frm_valid=1 and frm_ready=0.

## Test plan
- Idle MAC: control read returns 32'h0 with zero-wait slave, POLL_GAP=16 → arvalid to RX_CTRL every 18 cycles; frm_valid never rises; no writes.
- One frame: control reads 32'h1; data words at 0x1000..0x105C return 32'hA0000000+index; frm_ready=1 → 24 words emitted in order, frm_last only on 32'hA0000017. Then one write of 32'h0 to 13'h17FC, and frame_cnt=1.
- Backpressure: frm_ready toggles randomly, slave inserts random 0–5 cycle waits on every ready/valid → same 24-word sequence; frm_data stable while stalled; never more than one outstanding transaction.
- Write-channel skew: awready delayed 4 cycles, wready immediate → wvalid drops after 1 cycle, awvalid after 5; bready follows; single write.
- Errors: rresp=2'b10 on data word 5, then bresp=2'b10 → err_sticky=1 from that rvalid; all 24 words still emitted; frame_cnt increments.
- Reset mid-frame at word 10, and enable=0 during a frame: after reset all outputs are 0 and polling restarts. With enable=0, the current frame completes and is released, and no further AR is issued.

Source files
------------

// File: rtl/ntps_ethlite_rx_drain.sv
// ntps_ethlite_rx_drain: AXI4-Lite master that drains the Ethernet Lite
// RX ping buffer into a 32-bit word stream for the NTP packet path.
module ntps_ethlite_rx_drain #(
  parameter int          FRAME_WORDS = 24,
  parameter int          POLL_GAP    = 16,
  parameter logic [12:0] RX_BASE     = 13'h1000,
  parameter logic [12:0] RX_CTRL     = 13'h17FC
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        enable,
  output logic [12:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [12:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] frm_data,
  output logic        frm_valid,
  output logic        frm_last,
  input  logic        frm_ready,
  output logic        err_sticky,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_POLL_AR,
    S_POLL_R,
    S_DATA_AR,
    S_DATA_R,
    S_DATA_OUT,
    S_CLR,
    S_CLR_B
  } state_t;

  localparam logic [15:0] GAP_MAX  = 16'(POLL_GAP - 1);
  localparam logic [8:0]  LAST_IDX = 9'(FRAME_WORDS - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_gap;
  logic [8:0]  r_idx;
  logic [8:0]  w_idx_next;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_frm_valid;
  logic        r_frm_last;
  logic        r_err;
  logic [12:0] r_araddr;
  logic [12:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [31:0] r_frm_data;
  logic [15:0] r_frame_cnt;

  logic w_ar_hs;
  logic w_r_hs;
  logic w_b_hs;
  logic w_aw_done;
  logic w_w_done;
  logic w_last;
  logic w_frame_rdy;

  assign w_ar_hs     = r_arvalid && m_axi_arready;
  assign w_r_hs      = r_rready && m_axi_rvalid;
  assign w_b_hs      = r_bready && m_axi_bvalid;
  assign w_aw_done   = !r_awvalid || m_axi_awready;
  assign w_w_done    = !r_wvalid || m_axi_wready;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_frame_rdy = m_axi_rdata[0] &&
                       (m_axi_rresp == 2'b00);

  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    unique case (r_state)
      S_WAIT: begin
        if (r_gap == GAP_MAX && enable)
          w_next = S_POLL_AR;
      end
      S_POLL_AR: begin
        if (w_ar_hs) w_next = S_POLL_R;
      end
      S_POLL_R: begin
        if (w_r_hs) begin
          if (w_frame_rdy) begin
            w_next     = S_DATA_AR;
            w_idx_next = '0;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_DATA_AR: begin
        if (w_ar_hs) w_next = S_DATA_R;
      end
      S_DATA_R: begin
        if (w_r_hs) w_next = S_DATA_OUT;
      end
      S_DATA_OUT: begin
        if (frm_ready) begin
          if (w_last) begin
            w_next = S_CLR;
          end else begin
            w_next     = S_DATA_AR;
            w_idx_next = r_idx + 9'd1;
          end
        end
      end
      S_CLR: begin
        if (w_aw_done && w_w_done)
          w_next = S_CLR_B;
      end
      S_CLR_B: begin
        if (w_b_hs) w_next = S_WAIT;
      end
      default: w_next = S_WAIT;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state     <= S_WAIT;
      r_gap       <= '0;
      r_idx       <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_frm_valid <= 1'b0;
      r_frm_last  <= 1'b0;
      r_err       <= 1'b0;
      r_araddr    <= '0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_frm_data  <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;

      // Valids are registered from the next state so they rise on entry
      r_arvalid <= (w_next == S_POLL_AR) ||
                   (w_next == S_DATA_AR);
      if (w_next == S_POLL_AR)
        r_araddr <= RX_CTRL;
      else if (w_next == S_DATA_AR)
        r_araddr <= RX_BASE + {2'b00, w_idx_next, 2'b00};

      r_rready    <= (w_next == S_POLL_R) ||
                     (w_next == S_DATA_R);
      r_bready    <= (w_next == S_CLR_B);
      r_frm_valid <= (w_next == S_DATA_OUT);

      if (r_state == S_DATA_R && w_r_hs) begin
        r_frm_data <= m_axi_rdata;
        r_frm_last <= w_last;
      end

      if (r_state == S_DATA_OUT && w_next == S_CLR) begin
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_awaddr  <= RX_CTRL;
        r_wdata   <= '0;
      end else begin
        if (m_axi_awready) r_awvalid <= 1'b0;
        if (m_axi_wready)  r_wvalid  <= 1'b0;
      end

      if (w_r_hs && m_axi_rresp != 2'b00) r_err <= 1'b1;
      if (w_b_hs && m_axi_bresp != 2'b00) r_err <= 1'b1;

      if (r_state == S_CLR_B && w_b_hs)
        r_frame_cnt <= r_frame_cnt + 16'd1;

      // Gap restarts on every return to WAIT and saturates there
      if (w_next == S_WAIT && r_state != S_WAIT)
        r_gap <= '0;
      else if (r_state == S_WAIT && r_gap != GAP_MAX)
        r_gap <= r_gap + 16'd1;
    end
  end

  assign m_axi_araddr  = r_araddr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign frm_data      = r_frm_data;
  assign frm_valid     = r_frm_valid;
  assign frm_last      = r_frm_last;
  assign err_sticky    = r_err;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_ntps_ethlite_rx_drain.sv
// tb_ntps_ethlite_rx_drain: randomized AXI4-Lite MAC model and frame
// scoreboard around ntps_ethlite_rx_drain.
`timescale 1ns/1ps
module tb_ntps_ethlite_rx_drain;

  localparam int          FW  = 24;
  localparam int          PG  = 16;
  localparam logic [12:0] RXB = 13'h1000;
  localparam logic [12:0] RXC = 13'h17FC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [12:0] araddr, awaddr;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0;
  logic        awready = 1'b0, wready = 1'b0;
  logic        bvalid = 1'b0;
  logic [31:0] rdata = '0, wdata, frm_data;
  logic [1:0]  rresp = '0, bresp = '0;
  logic [3:0]  wstrb;
  logic        frm_valid, frm_last, err;
  logic        frm_ready = 1'b0;
  logic [15:0] fcnt;

  always #5 clk = ~clk;

  ntps_ethlite_rx_drain #(
    .FRAME_WORDS(FW), .POLL_GAP(PG),
    .RX_BASE(RXB), .RX_CTRL(RXC)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .enable(enable),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready),
    .frm_data(frm_data), .frm_valid(frm_valid),
    .frm_last(frm_last), .frm_ready(frm_ready),
    .err_sticky(err), .frame_cnt(fcnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // MAC model state
  logic        ctrl = 1'b0;
  logic [31:0] mem [FW];
  int          max_w = 0, aw_extra = 0;
  int          err_word = -1;
  logic        b_err = 1'b0;
  logic        rdy_rand = 1'b0;

  // handshakes seen at the last posedge
  logic        l_ar, l_r, l_aw, l_w, l_b, l_f;
  logic        l_flast, l_err;
  logic [12:0] l_araddr, l_awaddr;
  logic [31:0] l_wdata, l_fdata;

  logic        rd_pend = 1'b0, aw_got = 1'b0;
  logic        w_got = 1'b0;
  logic [12:0] rd_addr, wr_addr, last_wa;
  logic [31:0] wr_dat, last_wd;
  int ar_c, ar_w, r_c, r_w, aw_c, aw_w;
  int w_c, w_w, b_c, b_w;

  int          ar_rise[$];
  logic [12:0] ar_rise_addr[$];
  logic [31:0] rx_d[$];
  logic        rx_l[$];
  logic        rx_e[$];
  int          rx_cyc[$];
  logic [31:0] exp_d[$];
  int wr_cnt = 0, viol = 0, unstable = 0;
  int aw_hi = 0, w_hi = 0, fv_rises = 0;
  logic        p_valid = 1'b0, p_ready, p_last;
  logic [31:0] p_data;
  logic        prev_arv = 1'b0, prev_fv = 1'b0;

  function automatic int pick(input int extra);
    if (max_w == 0) return extra;
    return extra + int'($urandom_range(0, max_w));
  endfunction

  function automatic logic [33:0] resp(
    input logic [12:0] a);
    int          idx;
    logic [31:0] d;
    logic [1:0]  rr;
    if (a == RXC) return {31'b0, ctrl, 2'b00};
    idx = int'((a - RXB) >> 2);
    d   = (idx >= 0 && idx < FW) ? mem[idx]
                                 : 32'hDEADBEEF;
    rr  = (idx == err_word) ? 2'b10 : 2'b00;
    return {d, rr};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      l_ar = 0; l_r = 0; l_aw = 0;
      l_w = 0; l_b = 0; l_f = 0;
    end else begin
      cyc++;
      l_ar = arvalid && arready;
      l_araddr = araddr;
      l_r = rvalid && rready;
      l_aw = awvalid && awready;
      l_awaddr = awaddr;
      l_w = wvalid && wready;
      l_wdata = wdata;
      l_b = bvalid && bready;
      l_f = frm_valid && frm_ready;
      l_fdata = frm_data;
      l_flast = frm_last;
      l_err = err;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      arready = 0; rvalid = 0; awready = 0;
      wready = 0; bvalid = 0;
      rd_pend = 0; aw_got = 0; w_got = 0;
      ar_c = 0; r_c = 0; aw_c = 0;
      w_c = 0; b_c = 0;
      p_valid = 0; prev_arv = 0; prev_fv = 0;
    end else begin
      if (l_ar) begin
        rd_pend = 1; rd_addr = l_araddr;
      end
      if (l_r) begin
        rvalid = 0; rd_pend = 0; r_c = 0;
      end
      if (l_aw) begin
        aw_got = 1; wr_addr = l_awaddr;
      end
      if (l_w) begin
        w_got = 1; wr_dat = l_wdata;
      end
      if (l_b) begin
        bvalid = 0; aw_got = 0; w_got = 0; b_c = 0;
        wr_cnt++;
        last_wa = wr_addr; last_wd = wr_dat;
        if (wr_addr == RXC) ctrl = wr_dat[0];
      end
      if (l_f) begin
        rx_d.push_back(l_fdata);
        rx_l.push_back(l_flast);
        rx_e.push_back(l_err);
        rx_cyc.push_back(cyc);
      end

      if (!arvalid) begin
        arready = 0; ar_c = 0;
      end else begin
        if (ar_c == 0) ar_w = pick(0);
        arready = (ar_c >= ar_w);
        ar_c++;
      end
      if (rd_pend && !rvalid) begin
        if (r_c == 0) r_w = pick(0);
        if (r_c >= r_w) begin
          rvalid = 1;
          {rdata, rresp} = resp(rd_addr);
        end
        r_c++;
      end
      if (!awvalid) begin
        awready = 0; aw_c = 0;
      end else begin
        if (aw_c == 0) aw_w = pick(aw_extra);
        awready = (aw_c >= aw_w);
        aw_c++;
      end
      if (!wvalid) begin
        wready = 0; w_c = 0;
      end else begin
        if (w_c == 0) w_w = pick(0);
        wready = (w_c >= w_w);
        w_c++;
      end
      if (aw_got && w_got && !bvalid) begin
        if (b_c == 0) b_w = pick(0);
        if (b_c >= b_w) begin
          bvalid = 1;
          bresp = b_err ? 2'b10 : 2'b00;
        end
        b_c++;
      end

      if (p_valid && !p_ready) begin
        if (!(frm_valid && frm_data == p_data &&
              frm_last == p_last))
          unstable++;
      end
      frm_ready = rdy_rand ?
                  1'($urandom_range(0, 1)) : 1'b1;
      p_valid = frm_valid; p_ready = frm_ready;
      p_data = frm_data;   p_last = frm_last;

      if (arvalid && !prev_arv) begin
        ar_rise.push_back(cyc + 1);
        ar_rise_addr.push_back(araddr);
      end
      prev_arv = arvalid;
      if (frm_valid && !prev_fv) fv_rises++;
      prev_fv = frm_valid;
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (arvalid && rd_pend) viol++;
      if ((arvalid || rd_pend) &&
          (awvalid || wvalid || aw_got ||
           w_got || bvalid))
        viol++;
    end
  end

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string t);
    chk({t, "_arvalid"}, int'(arvalid), 0);
    chk({t, "_rready"}, int'(rready), 0);
    chk({t, "_awvalid"}, int'(awvalid), 0);
    chk({t, "_wvalid"}, int'(wvalid), 0);
    chk({t, "_bready"}, int'(bready), 0);
    chk({t, "_frm_valid"}, int'(frm_valid), 0);
    chk({t, "_araddr"}, int'(araddr), 0);
    chk({t, "_awaddr"}, int'(awaddr), 0);
    chk({t, "_wdata"}, int'(wdata), 0);
    chk({t, "_frm_data"}, int'(frm_data), 0);
    chk({t, "_frm_last"}, int'(frm_last), 0);
    chk({t, "_err"}, int'(err), 0);
    chk({t, "_fcnt"}, int'(fcnt), 0);
    chk({t, "_wstrb"}, int'(wstrb), 'hF);
  endtask

  task automatic clear_rx();
    rx_d.delete(); rx_l.delete();
    rx_e.delete(); rx_cyc.delete();
  endtask

  // Reference: a released frame is mem[0..FW-1] in order
  task automatic start_frame();
    @(negedge clk); #1;
    clear_rx();
    exp_d.delete();
    for (int i = 0; i < FW; i++)
      exp_d.push_back(mem[i]);
    ctrl = 1'b1;
  endtask

  task automatic wait_fcnt(input int tgt);
    for (int i = 0; i < 8000 && int'(fcnt) != tgt;
         i++) begin
      @(negedge clk); #1;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 4000 && rx_d.size() < n;
         i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic check_frame(input string t);
    int bad;
    bad = 0;
    chk({t, "_len"}, rx_d.size(), FW);
    for (int i = 0; i < rx_d.size() && i < FW; i++)
      if (rx_d[i] !== exp_d[i] ||
          rx_l[i] !== (i == FW - 1))
        bad++;
    chk({t, "_words"}, bad, 0);
  endtask

  initial begin
    int n, bad, wc;
    for (int i = 0; i < FW; i++)
      mem[i] = 32'hA0000000 + i;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;

    // idle MAC: periodic polls only
    for (int i = 0; i < 300 && ar_rise.size() < 4;
         i++) begin
      @(negedge clk); #1;
    end
    chk("idle_polls", int'(ar_rise.size() >= 4), 1);
    if (ar_rise.size() >= 4) begin
      chk("first_poll_cyc", ar_rise[0], PG + 1);
      for (int i = 1; i < 4; i++) begin
        chk("poll_period", ar_rise[i] - ar_rise[i-1],
            PG + 2);
        chk("poll_addr", int'(ar_rise_addr[i]),
            int'(RXC));
      end
    end
    chk("idle_no_frm", fv_rises, 0);
    chk("idle_no_wr", wr_cnt, 0);

    // one frame, zero-wait slave
    start_frame();
    wait_fcnt(1);
    chk("f1_cnt", int'(fcnt), 1);
    check_frame("f1");
    bad = 0;
    for (int i = 1; i < rx_cyc.size(); i++)
      if (rx_cyc[i] - rx_cyc[i-1] != 3) bad++;
    chk("f1_rate", bad, 0);
    chk("f1_wr_cnt", wr_cnt, 1);
    chk("f1_wr_addr", int'(last_wa), int'(RXC));
    chk("f1_wr_data", int'(last_wd), 0);
    chk("f1_ctrl", int'(ctrl), 0);
    chk("f1_err", int'(err), 0);

    // backpressure with random data
    max_w = 5;
    rdy_rand = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FW; i++)
        mem[i] = $urandom;
      start_frame();
      wait_fcnt(2 + f);
      chk("bp_cnt", int'(fcnt), 2 + f);
      check_frame("bp");
    end
    chk("bp_stable", unstable, 0);
    chk("bp_wr_cnt", wr_cnt, 3);

    // write channel skew
    max_w = 0;
    rdy_rand = 1'b0;
    aw_extra = 4;
    @(negedge clk); #1;
    aw_hi = 0; w_hi = 0;
    start_frame();
    wait_fcnt(4);
    chk("skew_cnt", int'(fcnt), 4);
    chk("skew_aw_hi", aw_hi, 5);
    chk("skew_w_hi", w_hi, 1);
    chk("skew_wr_cnt", wr_cnt, 4);
    aw_extra = 0;

    // error responses
    max_w = 2;
    err_word = 5;
    b_err = 1'b1;
    for (int i = 0; i < FW; i++)
      mem[i] = $urandom;
    start_frame();
    wait_fcnt(5);
    chk("err_cnt", int'(fcnt), 5);
    check_frame("err");
    if (rx_e.size() > 5) begin
      chk("err_before", int'(rx_e[4]), 0);
      chk("err_after", int'(rx_e[5]), 1);
    end
    chk("err_sticky", int'(err), 1);
    err_word = -1;
    b_err = 1'b0;
    max_w = 0;

    // reset mid-frame at word 10
    for (int i = 0; i < FW; i++)
      mem[i] = 32'hA0000000 + i;
    start_frame();
    wait_words(10);
    chk("mid_words", rx_d.size(), 10);
    wc = wr_cnt;
    #2 rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    repeat (2) @(negedge clk);
    #1;
    clear_rx();
    ar_rise.delete();
    ar_rise_addr.delete();
    chk("mid_unreleased", int'(ctrl), 1);
    chk("mid_no_wr", wr_cnt, wc);
    rst_n = 1'b1;
    wait_fcnt(1);
    chk("mid_cnt", int'(fcnt), 1);
    check_frame("mid");
    if (ar_rise.size() > 0) begin
      chk("mid_repoll_cyc", ar_rise[0], PG + 1);
      chk("mid_repoll_addr", int'(ar_rise_addr[0]),
          int'(RXC));
    end
    chk("mid_err", int'(err), 0);

    // enable dropped mid-frame
    start_frame();
    wait_words(5);
    enable = 1'b0;
    wait_fcnt(2);
    chk("en_cnt", int'(fcnt), 2);
    check_frame("en");
    chk("en_ctrl", int'(ctrl), 0);
    n = ar_rise.size();
    repeat (100) @(negedge clk);
    #1;
    chk("en_no_ar", ar_rise.size(), n);
    chk("en_arvalid", int'(arvalid), 0);

    chk("one_outstanding", viol, 0);
    chk("frm_stable", unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
